// File: rtl/ddr3_arb_pkg.sv
// ddr3_arb_pkg
//   Shared definitions for the DDR3 user-interface request arbiter:
//   UI command encodings, arbiter FSM state type, err_flags bit indices
//   and a helper that classifies a latched request as issuable or not.
package ddr3_arb_pkg;

   localparam logic [2:0] CMD_WRITE = 3'd0;
   localparam logic [2:0] CMD_READ  = 3'd1;
   localparam logic [2:0] CMD_IDLE  = 3'd2;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_BUSY,
      ST_DONE
   } arb_state_t;

   localparam int ERR_ILLEGAL_CMD = 0;
   localparam int ERR_TIMEOUT     = 1;

   function automatic logic cmd_known(input logic [2:0] cmd);
      return (cmd == CMD_WRITE) || (cmd == CMD_READ);
   endfunction

   // A request reaches the controller only with a known command and a
   // non-zero beat count; anything else is retired without a command.
   function automatic logic cmd_issuable(input logic [2:0] cmd, input logic [31:0] size);
      return cmd_known(cmd) && (size != 32'd0);
   endfunction

endpackage

// File: rtl/ddr3_req_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin picker. Searches the eligible vector starting
//   one position after last_grant, wrapping from NUM_REQ-1 back to 0.
//   Ports:
//     eligible   - per-requester eligibility
//     last_grant - index of the most recently completed grant
//     grant_idx  - first eligible index after last_grant (0 when none)
//     any        - at least one requester is eligible
module rr_pick #(
   parameter int NUM_REQ = 4,
   parameter int IDX_W   = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] eligible,
   input  logic [IDX_W-1:0]   last_grant,
   output logic [IDX_W-1:0]   grant_idx,
   output logic               any
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      grant_idx = '0;
      any       = 1'b0;
      cand      = '0;
      for (int unsigned off = 1; off <= NUM_REQ; off++) begin
         cand = IDX_W'((32'(last_grant) + off) % NUM_REQ);
         if (!any && eligible[cand]) begin
            any       = 1'b1;
            grant_idx = cand;
         end
      end
   end

endmodule

// File: rtl/ddr3_req_arbiter.sv
// ddr3_req_arbiter
//   Shares the single DDR3 UI command port among NUM_REQ burst requesters.
//   Grants round-robin, holds the grant until the controller reports the
//   matching finish (or a timeout), and routes write-data and read-valid
//   handshakes to the granted requester. Before init_done only requester 0
//   may be granted.
//   Ports:
//     ui_clk, ui_rst          - clock, asynchronous active-high reset
//     init_done               - opens arbitration to all requesters
//     req_valid/cmd/addr/size - per-requester burst request fields
//     req_wdf_data/valid      - per-requester write data
//     req_ready, req_done     - per-requester accept / completion pulses
//     req_wdf_rdy, req_rd_valid - routed controller strobes
//     ddr_*                   - controller UI command and data port
//     err_flags               - sticky: bit0 illegal cmd, bit1 timeout
module ddr3_req_arbiter
   import ddr3_arb_pkg::*;
#(
   parameter int NUM_REQ        = 4,
   parameter int ADDR_WIDTH     = 29,
   parameter int UI_WIDTH       = 512,
   parameter int SIZE_WIDTH     = 10,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic                           ui_clk,
   input  logic                           ui_rst,
   input  logic                           init_done,
   input  logic [NUM_REQ-1:0]             req_valid,
   input  logic [NUM_REQ*3-1:0]           req_cmd,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
   input  logic [NUM_REQ*SIZE_WIDTH-1:0]  req_size,
   input  logic [NUM_REQ*UI_WIDTH-1:0]    req_wdf_data,
   input  logic [NUM_REQ-1:0]             req_wdf_valid,
   output logic [NUM_REQ-1:0]             req_ready,
   output logic [NUM_REQ-1:0]             req_done,
   output logic [NUM_REQ-1:0]             req_wdf_rdy,
   output logic [NUM_REQ-1:0]             req_rd_valid,
   input  logic                           ddr_rdy,
   input  logic                           ddr_wdf_data_rdy,
   input  logic                           ddr_rd_data_valid,
   input  logic                           ddr_wr_finish,
   input  logic                           ddr_rd_finish,
   output logic [2:0]                     ddr_cmd,
   output logic                           ddr_cmd_valid,
   output logic [ADDR_WIDTH-1:0]          ddr_base_addr,
   output logic [SIZE_WIDTH-1:0]          ddr_size,
   output logic [UI_WIDTH-1:0]            ddr_wdf_data,
   output logic                           ddr_wdf_data_valid,
   output logic [1:0]                     err_flags
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);

   arb_state_t       state;
   logic [IDX_W-1:0] grant;
   logic [IDX_W-1:0] last_grant;
   logic [2:0]       cmd_q;
   logic [TW-1:0]    tmo_cnt;

   logic [NUM_REQ-1:0]    eligible;
   logic [IDX_W-1:0]      pick_idx;
   logic                  pick_any;
   logic [2:0]            pick_cmd;
   logic [SIZE_WIDTH-1:0] pick_size;
   logic [NUM_REQ-1:0]    grant_onehot;
   logic                  fin_match;
   logic                  active;

   always_comb begin
      eligible = req_valid;
      if (!init_done)
         eligible = req_valid & NUM_REQ'(1);
   end

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_rr_pick (
      .eligible   (eligible),
      .last_grant (last_grant),
      .grant_idx  (pick_idx),
      .any        (pick_any)
   );

   assign pick_cmd     = req_cmd[pick_idx*3 +: 3];
   assign pick_size    = req_size[pick_idx*SIZE_WIDTH +: SIZE_WIDTH];
   assign grant_onehot = NUM_REQ'(1) << grant;
   assign fin_match    = ((cmd_q == CMD_WRITE) && ddr_wr_finish) ||
                         ((cmd_q == CMD_READ)  && ddr_rd_finish);
   assign active       = (state == ST_ISSUE) || (state == ST_BUSY);

   // The command outputs double as the latch registers for addr and size;
   // cmd_q keeps the command because ddr_cmd is forced to idle in DONE.
   always_ff @(posedge ui_clk or posedge ui_rst) begin
      if (ui_rst) begin
         state         <= ST_IDLE;
         grant         <= '0;
         last_grant    <= IDX_W'(NUM_REQ - 1);
         cmd_q         <= CMD_IDLE;
         tmo_cnt       <= '0;
         req_ready     <= '0;
         req_done      <= '0;
         ddr_cmd       <= CMD_IDLE;
         ddr_cmd_valid <= 1'b0;
         ddr_base_addr <= '0;
         ddr_size      <= '0;
         err_flags     <= '0;
      end else begin
         req_ready <= '0;
         req_done  <= '0;
         case (state)
            ST_IDLE: begin
               if (ddr_rdy && pick_any) begin
                  state         <= ST_ISSUE;
                  grant         <= pick_idx;
                  cmd_q         <= pick_cmd;
                  req_ready     <= NUM_REQ'(1) << pick_idx;
                  ddr_cmd       <= pick_cmd;
                  ddr_base_addr <= req_addr[pick_idx*ADDR_WIDTH +: ADDR_WIDTH];
                  ddr_size      <= pick_size;
                  ddr_cmd_valid <= cmd_issuable(pick_cmd, 32'(pick_size));
               end
            end
            ST_ISSUE: begin
               if (!cmd_issuable(cmd_q, 32'(ddr_size)) || fin_match) begin
                  state         <= ST_DONE;
                  req_done      <= grant_onehot;
                  ddr_cmd       <= CMD_IDLE;
                  ddr_cmd_valid <= 1'b0;
                  if (!cmd_known(cmd_q))
                     err_flags[ERR_ILLEGAL_CMD] <= 1'b1;
               end else begin
                  state   <= ST_BUSY;
                  tmo_cnt <= '0;
               end
            end
            ST_BUSY: begin
               if (fin_match || (tmo_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
                  state         <= ST_DONE;
                  req_done      <= grant_onehot;
                  ddr_cmd       <= CMD_IDLE;
                  ddr_cmd_valid <= 1'b0;
                  if (!fin_match)
                     err_flags[ERR_TIMEOUT] <= 1'b1;
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            ST_DONE: begin
               last_grant <= grant;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      req_wdf_rdy        = '0;
      req_rd_valid       = '0;
      ddr_wdf_data       = '0;
      ddr_wdf_data_valid = 1'b0;
      if (active) begin
         ddr_wdf_data = req_wdf_data[grant*UI_WIDTH +: UI_WIDTH];
         if (cmd_q == CMD_WRITE) begin
            req_wdf_rdy[grant] = ddr_wdf_data_rdy;
            ddr_wdf_data_valid = req_wdf_valid[grant];
         end
         if (cmd_q == CMD_READ)
            req_rd_valid[grant] = ddr_rd_data_valid;
      end
   end

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// tb_ddr3_req_arbiter
//   Directed-vector bench for ddr3_req_arbiter with hand-computed
//   expectations: reset state, init gating, round-robin order, read
//   routing, zero-size / illegal commands, timeout and mid-burst reset.
module tb_ddr3_req_arbiter;

   localparam int NR = 4;
   localparam int AW = 29;
   localparam int UW = 512;
   localparam int SW = 10;

   logic              ui_clk = 1'b0;
   logic              ui_rst = 1'b1;
   logic              init_done = 1'b0;
   logic [NR-1:0]     req_valid = '0;
   logic [NR*3-1:0]   req_cmd = '0;
   logic [NR*AW-1:0]  req_addr = '0;
   logic [NR*SW-1:0]  req_size = '0;
   logic [NR*UW-1:0]  req_wdf_data = '0;
   logic [NR-1:0]     req_wdf_valid = '0;
   logic [NR-1:0]     req_ready, req_done, req_wdf_rdy, req_rd_valid;
   logic              ddr_rdy = 1'b1;
   logic              ddr_wdf_data_rdy = 1'b0;
   logic              ddr_rd_data_valid = 1'b0;
   logic              ddr_wr_finish = 1'b0;
   logic              ddr_rd_finish = 1'b0;
   logic [2:0]        ddr_cmd;
   logic              ddr_cmd_valid;
   logic [AW-1:0]     ddr_base_addr;
   logic [SW-1:0]     ddr_size;
   logic [UW-1:0]     ddr_wdf_data;
   logic              ddr_wdf_data_valid;
   logic [1:0]        err_flags;

   int n_checks = 0;
   int n_errors = 0;

   always #5 ui_clk = ~ui_clk;

   ddr3_req_arbiter #(
      .NUM_REQ        (NR),
      .ADDR_WIDTH     (AW),
      .UI_WIDTH       (UW),
      .SIZE_WIDTH     (SW),
      .TIMEOUT_CYCLES (16)
   ) dut (
      .ui_clk             (ui_clk),
      .ui_rst             (ui_rst),
      .init_done          (init_done),
      .req_valid          (req_valid),
      .req_cmd            (req_cmd),
      .req_addr           (req_addr),
      .req_size           (req_size),
      .req_wdf_data       (req_wdf_data),
      .req_wdf_valid      (req_wdf_valid),
      .req_ready          (req_ready),
      .req_done           (req_done),
      .req_wdf_rdy        (req_wdf_rdy),
      .req_rd_valid       (req_rd_valid),
      .ddr_rdy            (ddr_rdy),
      .ddr_wdf_data_rdy   (ddr_wdf_data_rdy),
      .ddr_rd_data_valid  (ddr_rd_data_valid),
      .ddr_wr_finish      (ddr_wr_finish),
      .ddr_rd_finish      (ddr_rd_finish),
      .ddr_cmd            (ddr_cmd),
      .ddr_cmd_valid      (ddr_cmd_valid),
      .ddr_base_addr      (ddr_base_addr),
      .ddr_size           (ddr_size),
      .ddr_wdf_data       (ddr_wdf_data),
      .ddr_wdf_data_valid (ddr_wdf_data_valid),
      .err_flags          (err_flags)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge ui_clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [2:0] c, input logic [AW-1:0] a,
                          input logic [SW-1:0] s);
      req_cmd[i*3 +: 3]    = c;
      req_addr[i*AW +: AW] = a;
      req_size[i*SW +: SW] = s;
   endtask

   // Returns the number of clock edges until req_ready appears.
   task automatic wait_ready(input string tag, output int cycles);
      cycles = 0;
      while (req_ready == '0 && cycles < 30) begin
         tick();
         cycles++;
      end
      if (req_ready == '0)
         check({tag, "_ready_timeout"}, {63'd0, req_ready != '0}, 64'd1);
   endtask

   int c;
   int exp_order [4] = '{1, 2, 3, 1};
   logic [5:0] pat;
   int beats, others;

   initial begin
      // ---- reset state, init_done gating ----
      set_req(0, 3'd0, 29'h0, 10'd56);
      set_req(2, 3'd1, 29'h100, 10'd8);
      req_wdf_data[63:0]       = 64'hDEAD_BEEF_0123_4567;
      req_wdf_data[UW +: 64]   = 64'h1111_2222_3333_4444;
      req_wdf_valid            = 4'b0001;
      ddr_wdf_data_rdy         = 1'b1;
      req_valid                = 4'b0101;
      tick();
      check("rst_ddr_cmd", ddr_cmd, 2);
      check("rst_cmd_valid", ddr_cmd_valid, 0);
      check("rst_ready", req_ready, 0);
      check("rst_err", err_flags, 0);
      check("rst_wdf_rdy", req_wdf_rdy, 0);
      ui_rst = 1'b0;
      tick();
      check("t1_ready", req_ready, 4'b0001);
      check("t1_cmd", ddr_cmd, 0);
      check("t1_addr", ddr_base_addr, 0);
      check("t1_size", ddr_size, 56);
      check("t1_cmd_valid", ddr_cmd_valid, 1);
      check("t1_wdf_rdy", req_wdf_rdy, 4'b0001);
      check("t1_wdf_valid", ddr_wdf_data_valid, 1);
      check("t1_wdf_data", ddr_wdf_data[63:0], 64'hDEAD_BEEF_0123_4567);
      req_valid = 4'b0100;
      tick();
      check("t1_busy_valid", ddr_cmd_valid, 1);
      check("t1_busy_ready", req_ready, 0);
      ddr_wr_finish = 1'b1;
      tick();
      ddr_wr_finish = 1'b0;
      check("t1_done", req_done, 4'b0001);
      check("t1_done_cmd", ddr_cmd, 2);
      check("t1_done_valid", ddr_cmd_valid, 0);
      check("t1_done_wdf_rdy", req_wdf_rdy, 0);
      tick(); tick(); tick();
      check("t1_gate_ready", req_ready, 0);
      check("t1_gate_valid", ddr_cmd_valid, 0);

      // ---- round-robin 1,2,3,1 with continuous requests ----
      set_req(1, 3'd0, 29'h10, 10'd4);
      set_req(2, 3'd0, 29'h20, 10'd4);
      set_req(3, 3'd0, 29'h30, 10'd4);
      init_done = 1'b1;
      req_valid = 4'b1110;
      for (int k = 0; k < 4; k++) begin
         wait_ready("t2", c);
         check($sformatf("t2_grant%0d", k), req_ready, 4'(1) << exp_order[k]);
         if (k > 0)
            check($sformatf("t2_latency%0d", k), c, 2);
         ddr_wr_finish = 1'b1;     // finish during ISSUE counts
         tick();
         ddr_wr_finish = 1'b0;
         check($sformatf("t2_done%0d", k), req_done, 4'(1) << exp_order[k]);
      end
      req_valid = '0;

      // ---- read by req 2, routed beats, spurious write finish ----
      set_req(2, 3'd1, 29'h1234, 10'd4);
      req_valid = 4'b0100;
      wait_ready("t3", c);
      check("t3_ready", req_ready, 4'b0100);
      check("t3_cmd", ddr_cmd, 1);
      check("t3_addr", ddr_base_addr, 29'h1234);
      check("t3_size", ddr_size, 4);
      check("t3_no_wdf_rdy", req_wdf_rdy, 0);
      req_valid = '0;
      tick();
      ddr_wr_finish = 1'b1;
      tick();
      ddr_wr_finish = 1'b0;
      check("t3_spurious_valid", ddr_cmd_valid, 1);
      check("t3_spurious_done", req_done, 0);
      pat = 6'b101101;
      beats = 0;
      others = 0;
      for (int i = 0; i < 6; i++) begin
         ddr_rd_data_valid = pat[i];
         #1;
         if (req_rd_valid[2]) beats++;
         if ((req_rd_valid & 4'b1011) != '0) others++;
         tick();
      end
      ddr_rd_data_valid = 1'b0;
      check("t3_beats", beats, 4);
      check("t3_others", others, 0);
      ddr_rd_finish = 1'b1;
      tick();
      ddr_rd_finish = 1'b0;
      check("t3_done", req_done, 4'b0100);

      // ---- size 0, then illegal cmd 5 ----
      set_req(1, 3'd0, 29'h40, 10'd0);
      req_valid = 4'b0010;
      wait_ready("t4", c);
      check("t4a_ready", req_ready, 4'b0010);
      check("t4a_cmd_valid", ddr_cmd_valid, 0);
      req_valid = '0;
      tick();
      check("t4a_done", req_done, 4'b0010);
      check("t4a_err", err_flags, 2'b00);
      tick();
      set_req(1, 3'd5, 29'h44, 10'd4);
      req_valid = 4'b0010;
      tick();
      check("t4b_ready", req_ready, 4'b0010);
      check("t4b_cmd_valid", ddr_cmd_valid, 0);
      req_valid = '0;
      tick();
      check("t4b_done", req_done, 4'b0010);
      check("t4b_err", err_flags, 2'b01);

      // ---- timeout after 16 BUSY cycles, then next request served ----
      set_req(3, 3'd0, 29'h50, 10'd8);
      req_valid = 4'b1000;
      wait_ready("t5", c);
      check("t5_ready", req_ready, 4'b1000);
      req_valid = '0;
      c = 0;
      do begin
         tick();
         c++;
      end while (req_done == '0 && c < 40);
      check("t5_tmo_cycles", c, 17);
      check("t5_tmo_done", req_done, 4'b1000);
      check("t5_err", err_flags, 2'b11);
      set_req(0, 3'd0, 29'h60, 10'd1);
      req_valid = 4'b0001;
      wait_ready("t5b", c);
      check("t5b_ready", req_ready, 4'b0001);
      req_valid = '0;
      ddr_wr_finish = 1'b1;
      tick();
      ddr_wr_finish = 1'b0;
      check("t5b_done", req_done, 4'b0001);

      // ---- reset during BUSY ----
      set_req(1, 3'd0, 29'h70, 10'd4);
      req_valid = 4'b0010;
      wait_ready("t6", c);
      check("t6_ready", req_ready, 4'b0010);
      tick();
      check("t6_busy_valid", ddr_cmd_valid, 1);
      req_valid = 4'b0011;
      ui_rst = 1'b1;
      #1;
      check("t6_rst_valid", ddr_cmd_valid, 0);
      check("t6_rst_cmd", ddr_cmd, 2);
      check("t6_rst_err", err_flags, 0);
      tick();
      check("t6_rst_done", req_done, 0);
      ui_rst = 1'b0;
      tick();
      check("t6_first_tie", req_ready, 4'b0001);
      check("t6_no_done", req_done, 0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
